// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcode encodings, opcode field position and the
// fetch sequencer state type.
package lc2k_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_NOOP = 3'd7;

  localparam int OPC_HI = 24;
  localparam int OPC_LO = 22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } fetch_state_e;

  function automatic logic [2:0] opcode_of(input logic [31:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register for fetched words. Flush drops the held word;
// a new load takes priority over the consumer draining the current one.
module fetch_out_reg #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              ready_i,
  input  logic [31:0]       instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic              valid_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// LC2K instruction fetch sequencer: owns the PC, arbitrates the single memory
// port between the program loader and fetch, and stops after a halt word.
module imem_fetch_ctrl
  import lc2k_pkg::*;
#(
  parameter int         ADDR_W  = 16,
  parameter logic [2:0] HALT_OP = OP_HALT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       fetch_count_q;
  logic              halted_q;

  logic idle_like;
  logic active;
  logic grant;
  logic redir;
  logic fire;
  logic accept;
  logic start_ok;
  logic halt_hit;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_HALT);
  assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign grant     = idle_like && load_valid;
  assign start_ok  = idle_like && start && !load_valid;
  assign redir     = active && redirect_valid;
  assign fire      = (state_q == ST_RUN) && (!out_valid || out_ready) && !redir;
  assign accept    = out_valid && out_ready && !redir;
  assign halt_hit  = (opcode_of(mem_instr) == HALT_OP);

  // The loader owns the memory port only while the sequencer is parked.
  assign load_ready = grant;
  assign mem_we     = grant;
  assign mem_wdata  = grant ? load_data : 32'd0;
  assign mem_addr   = {{(32-ADDR_W){1'b0}}, (grant ? load_addr : pc_q)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      fetch_count_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      if (accept)
        fetch_count_q <= fetch_count_q + 32'd1;
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start_ok) begin
            state_q       <= ST_RUN;
            pc_q          <= '0;
            fetch_count_q <= '0;
            halted_q      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (redir)
            pc_q <= redirect_pc;
          else if (fire) begin
            if (halt_hit)
              state_q <= ST_DRAIN;
            else
              pc_q <= pc_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (redir) begin
            state_q <= ST_RUN;
            pc_q    <= redirect_pc;
          end else if (out_valid && out_ready) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fetch_out_reg #(.ADDR_W(ADDR_W)) u_out (
    .clk     (clk),
    .rst     (reset),
    .load_i  (fire),
    .flush_i (redir),
    .ready_i (out_ready),
    .instr_i (mem_instr),
    .pc_i    (pc_q),
    .valid_o (out_valid),
    .instr_o (out_instr),
    .pc_o    (out_pc)
  );

  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule
